// File: rtl/vga_pkg.sv
// Shared VGA timing constants, background pattern codes and colour helpers
// used by the timing generator and the background pattern stage.
package vga_pkg;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT       = 16;
  localparam int unsigned H_SYNC        = 96;
  localparam int unsigned H_BACK        = 48;
  localparam int unsigned H_TOTAL       = H_VISIBLE_DEF + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT       = 10;
  localparam int unsigned V_SYNC        = 2;
  localparam int unsigned V_BACK        = 33;
  localparam int unsigned V_TOTAL       = V_VISIBLE_DEF + V_FRONT + V_SYNC + V_BACK;

  localparam logic [7:0] BG_SOLID    = 8'd0;
  localparam logic [7:0] BG_BARS     = 8'd1;
  localparam logic [7:0] BG_CHECKER  = 8'd2;
  localparam logic [7:0] BG_GRADIENT = 8'd3;

  localparam logic [5:0] RESET_COLOR = 6'b101010;

  // Configuration word as it crosses from the SCLK domain.
  typedef struct packed {
    logic [7:0] bg;
    logic [5:0] col;
  } bg_cfg_t;

  // Eight-bar palette: each bar index bit drives both bits of one channel.
  function automatic logic [5:0] bar_color(input logic [2:0] b);
    return {b[2], b[2], b[1], b[1], b[0], b[0]};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters, completed-frame counter and
// combinational sync/active decode of the current counter position.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned V_VISIBLE = 480
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic [7:0] frame_cnt,
  output logic       frame_start,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       active
);

  localparam int unsigned H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic h_wrap;
  logic v_wrap;

  assign h_wrap = (h == H_LAST);
  assign v_wrap = (v == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      h         <= '0;
      v         <= '0;
      frame_cnt <= '0;
    end else if (h_wrap) begin
      h <= '0;
      if (v_wrap) begin
        v         <= '0;
        frame_cnt <= frame_cnt + 8'd1;
      end else begin
        v <= v + 10'd1;
      end
    end else begin
      h <= h + 10'd1;
    end
  end

  always_comb begin
    hsync_raw   = !((h >= HS_START) && (h < HS_END));
    vsync_raw   = !((v >= VS_START) && (v < VS_END));
    active      = (h < H_VIS) && (v < V_VIS);
    frame_start = (h == '0) && (v == '0);
  end

endmodule

// File: rtl/background_gen.sv
// VGA background generator: synchronises SPI-domain pattern config, applies it
// at the first vblank cycle, and registers sync, position and pattern pixel.
module background_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned V_VISIBLE = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] background_state,
  input  logic [5:0] solid_color,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [5:0] rgb,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic [7:0] frame_cnt
);

  localparam logic [9:0] V_LOAD = 10'(V_VISIBLE);

  logic [9:0] h;
  logic [9:0] v;
  logic [7:0] fcnt;
  logic       frame_start;
  logic       hs_raw;
  logic       vs_raw;
  logic       active;

  vga_timing #(
    .H_VISIBLE(H_VISIBLE),
    .V_VISIBLE(V_VISIBLE)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .h          (h),
    .v          (v),
    .frame_cnt  (fcnt),
    .frame_start(frame_start),
    .hsync_raw  (hs_raw),
    .vsync_raw  (vs_raw),
    .active     (active)
  );

  bg_cfg_t    sync1;
  bg_cfg_t    sync2;
  bg_cfg_t    sync3;
  logic [7:0] bg_sh;
  logic [5:0] col_sh;
  logic [5:0] grad_ofs_q;
  logic [5:0] grad_ofs;
  logic [5:0] pat_rgb;
  logic       cfg_stable;
  logic       cfg_load;

  // A word is only trusted when two consecutive synchronised samples agree.
  assign cfg_stable = (sync2 == sync3);
  assign cfg_load   = cfg_stable && (h == '0) && (v == V_LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      sync3      <= '0;
      bg_sh      <= '0;
      col_sh     <= RESET_COLOR;
      grad_ofs_q <= '0;
    end else begin
      sync1 <= {background_state, solid_color};
      sync2 <= sync1;
      sync3 <= sync2;
      if (cfg_load) begin
        bg_sh  <= sync3.bg;
        col_sh <= sync3.col;
      end
      if (frame_start) begin
        grad_ofs_q <= fcnt[5:0];
      end
    end
  end

  // Scroll offset is captured at the first pixel, bypassed on that pixel itself.
  always_comb begin
    grad_ofs = frame_start ? fcnt[5:0] : grad_ofs_q;
    pat_rgb  = '0;
    case (bg_sh)
      BG_SOLID:    pat_rgb = col_sh;
      BG_BARS:     pat_rgb = bar_color(h[8:6]);
      BG_CHECKER:  pat_rgb = (h[5] ^ v[5]) ? ~col_sh : col_sh;
      BG_GRADIENT: pat_rgb = h[8:3] + grad_ofs;
      default:     pat_rgb = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      display_on <= 1'b0;
      rgb        <= '0;
      hpos       <= '0;
      vpos       <= '0;
      frame_cnt  <= '0;
    end else begin
      hsync      <= hs_raw;
      vsync      <= vs_raw;
      display_on <= active;
      rgb        <= active ? pat_rgb : '0;
      hpos       <= h;
      vpos       <= v;
      frame_cnt  <= fcnt;
    end
  end

endmodule

// File: tb/tb_background_gen.sv
// Directed bench for background_gen on a reduced 65x33 visible raster
// (blanking intervals unchanged): line 225 cycles, frame 78 lines.
module tb_background_gen;

  // Raster derived by hand: 65+16+96+48 = 225, 33+10+2+33 = 78, 225*78 = 17550.
  localparam int HV       = 65;
  localparam int VV       = 33;
  localparam int H_TOT    = 225;
  localparam int FRAME    = 17550;
  localparam int HS_START = 81;   // 65+16
  localparam int HS_LEN   = 96;
  localparam int VS_START = 43;   // 33+10
  localparam int VS_LEN   = 450;  // 2 lines

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] background_state;
  logic [5:0] solid_color;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic [5:0] rgb;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic [7:0] frame_cnt;

  background_gen #(
    .H_VISIBLE(HV),
    .V_VISIBLE(VV)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .background_state(background_state),
    .solid_color     (solid_color),
    .hsync           (hsync),
    .vsync           (vsync),
    .display_on      (display_on),
    .rgb             (rgb),
    .hpos            (hpos),
    .vpos            (vpos),
    .frame_cnt       (frame_cnt)
  );

  always #20 clk = ~clk;

  typedef struct packed {
    int         fr;
    int         h;
    int         v;
    logic [5:0] exp;
  } point_t;

  // Hand-computed pixels; shadow colour is 2D (~2D = 12) once loaded.
  point_t pts [13] = '{
    '{1, 20,  3, 6'h2A},  // unstable boundary: reset colour retained
    '{1, 64, 32, 6'h2A},
    '{3,  0,  0, 6'h2D},  // checker
    '{3, 32,  0, 6'h12},
    '{3, 32, 32, 6'h2D},
    '{3,  0, 32, 6'h12},
    '{3, 70,  0, 6'h00},  // horizontal blanking
    '{4,  0,  0, 6'h00},  // bars
    '{4, 64,  0, 6'h03},
    '{4, 63,  5, 6'h00},
    '{5,  8,  0, 6'd6},   // gradient, frame_cnt 5: 1+5
    '{5, 16,  2, 6'd7},   // 2+5
    '{5, 64, 10, 6'd13}   // 8+5
  };

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  fr, cyc, last_fs;
    int  disp_bad, solid_bad, blk_bad;
    int  hs_run, hs_start, vs_run, vs_start_v, vs_start_h;
    bit  prev_hs, prev_vs, done, win;
    int  exp_rgb;

    rst              = 1'b1;
    background_state = 8'd0;
    solid_color      = 6'h2D;
    repeat (3) step();
    rst = 1'b0;
    repeat (300) step();

    // Mid-frame reset held for 5 edges.
    rst = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      step();
      check("rst_hsync", hsync, 1);
      check("rst_vsync", vsync, 1);
      check("rst_rgb", rgb, 0);
      check("rst_disp", display_on, 0);
      check("rst_fcnt", frame_cnt, 0);
    end
    rst = 1'b0;
    step();
    check("post_hpos", hpos, 0);
    check("post_vpos", vpos, 0);
    check("post_disp", display_on, 1);
    check("post_hsync", hsync, 1);
    check("post_vsync", vsync, 1);
    check("post_rgb", rgb, 6'h2A);
    check("post_fcnt", frame_cnt, 0);

    fr = 0; cyc = 0; last_fs = 0;
    disp_bad = 0; solid_bad = 0; blk_bad = 0;
    hs_run = 0; hs_start = 0; vs_run = 0; vs_start_v = 0; vs_start_h = 0;
    prev_hs = 1'b1; prev_vs = 1'b1; done = 1'b0;

    while (!done && cyc < 7 * FRAME) begin
      step();
      cyc++;

      if (hpos == 0 && vpos == 0) begin
        if (fr == 2) check("solid_scan", solid_bad, 0);
        check($sformatf("disp_scan_f%0d", fr), disp_bad, 0);
        disp_bad = 0;
        fr++;
        check($sformatf("frame_period_f%0d", fr), cyc - last_fs, FRAME);
        last_fs = cyc;
        check($sformatf("frame_cnt_f%0d", fr), frame_cnt, fr);
      end

      if (display_on != (hpos < HV && vpos < VV)) disp_bad++;
      if (fr == 2) begin
        exp_rgb = (hpos < HV && vpos < VV) ? 6'h2D : 0;
        if (rgb != exp_rgb) solid_bad++;
      end
      if (fr == 6 && rgb != 0) blk_bad++;

      foreach (pts[i]) begin
        if (pts[i].fr == fr && pts[i].h == hpos && pts[i].v == vpos)
          check($sformatf("pix_f%0d_%0d_%0d", fr, hpos, vpos), rgb, pts[i].exp);
      end

      if (prev_hs && !hsync) begin hs_start = hpos; hs_run = 0; end
      if (!hsync) hs_run++;
      if (!prev_hs && hsync) begin
        check("hsync_len", hs_run, HS_LEN);
        check("hsync_start", hs_start, HS_START);
      end
      prev_hs = hsync;

      if (prev_vs && !vsync) begin vs_start_v = vpos; vs_start_h = hpos; vs_run = 0; end
      if (!vsync) vs_run++;
      if (!prev_vs && vsync) begin
        check("vsync_len", vs_run, VS_LEN);
        check("vsync_start_v", vs_start_v, VS_START);
        check("vsync_start_h", vs_start_h, 0);
      end
      prev_vs = vsync;

      // Stimulus keyed on the observed raster position.
      win = (vpos == VV - 1 && hpos >= H_TOT - 40) || (vpos == VV && hpos < 40);
      if (fr == 0 && win) solid_color = (solid_color == 6'h2D) ? 6'h12 : 6'h2D;
      else                solid_color = 6'h2D;
      if (fr == 2 && vpos == 16 && hpos == 0) background_state = 8'd2;
      if (fr == 3 && vpos == 1 && hpos == 0)  background_state = 8'd1;
      if (fr == 4 && vpos == 1 && hpos == 0)  background_state = 8'd3;
      if (fr == 5 && vpos == 1 && hpos == 0)  background_state = 8'd7;
      if (fr == 6 && vpos == 2 && hpos == 0) begin
        check("black_scan", blk_bad, 0);
        done = 1'b1;
      end
    end

    check("run_complete", done, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
